soundrive_fifo_player: RTL and testbench

- Buffered sample scheduler sitting in front of the covox/soundrive DAC channel registers.
- CPU streams sample bytes into a FIFO through an I/O port. A programmable rate timer pops samples at a fixed sample rate onto the four 8-bit DAC channel outputs, giving jitter-free playback independent of CPU timing.
- Outputs feed the existing channel mixer in place of, or muxed with, the direct-write covox/soundrive registers.

---
 rtl/soundrive_fifo_player_if.sv | 11 +
 rtl/soundrive_fifo_player.sv | 110 +++++++++++
 tb/tb_soundrive_fifo_player.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soundrive_fifo_player_if.sv
// CPU I/O bus as seen by the soundrive FIFO player: request, strobes, address and write data.
interface cpu_bus;
    logic       ioreq;
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;

    modport master (output ioreq, rd, wr, a, d);
    modport slave  (input  ioreq, rd, wr, a, d);
endinterface

// File: rtl/soundrive_fifo_player.sv
// Buffered covox/soundrive sample player: the CPU fills a byte FIFO through I/O ports and a
// programmable rate timer pops samples onto the four DAC channel outputs at a fixed rate.
module soundrive_fifo_player #(
    parameter int         DEPTH     = 32,
    parameter logic [7:0] DIV_RESET = 8'h0F
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       en,
    cpu_bus.slave      bus,
    output logic [7:0] d_out,
    output logic       d_out_active,
    output logic [7:0] ch_l0,
    output logic [7:0] ch_l1,
    output logic [7:0] ch_r0,
    output logic [7:0] ch_r1
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [5:0] DEPTH_L = 6'(DEPTH);
    localparam logic [7:0] SILENCE = 8'h80;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [5:0]    level;
    logic [7:0]    div, divcnt;
    logic [5:0]    prescaler;
    logic          mode, overrun, underrun;

    // Strobe bits: [0] data push, [1] control write, [2] divider write, [3] status read.
    logic          sel;
    logic [3:0]    strobe, strobe_p1, access;
    logic          flush, tick, pop_ok, push_ok, push_drop;
    logic [1:0]    pop_cnt;

    assign sel       = en && bus.ioreq;
    assign strobe[0] = sel && bus.wr && (bus.a == 8'h3F);
    assign strobe[1] = sel && bus.wr && (bus.a == 8'h7F);
    assign strobe[2] = sel && bus.wr && (bus.a == 8'hBF);
    assign strobe[3] = sel && bus.rd && (bus.a == 8'h7F);
    assign access    = strobe & ~strobe_p1;

    assign d_out_active = strobe[3];
    assign d_out        = d_out_active ? {overrun, underrun, level} : 8'h00;

    // A flush cycle swallows both a coincident tick and a coincident push.
    assign flush     = !en || (access[1] && bus.d[7]);
    assign tick      = !flush && (prescaler == 6'd63) && (divcnt == 8'd0);
    assign pop_ok    = tick && (mode ? (level >= 6'd2) : (level >= 6'd1));
    assign pop_cnt   = pop_ok ? (mode ? 2'd2 : 2'd1) : 2'd0;
    assign push_ok   = access[0] && !flush && (level < DEPTH_L);
    assign push_drop = access[0] && !flush && (level >= DEPTH_L);

    always_ff @(posedge clk28) begin
        if (push_ok) mem[wr_ptr] <= bus.d;
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            strobe_p1 <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            div       <= DIV_RESET;
            divcnt    <= DIV_RESET;
            prescaler <= '0;
            mode      <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
            ch_l0     <= SILENCE;
            ch_l1     <= SILENCE;
            ch_r0     <= SILENCE;
            ch_r1     <= SILENCE;
        end else begin
            strobe_p1 <= strobe;
            if (access[1]) mode <= bus.d[0];
            if (access[2]) div  <= bus.d;

            // Setting a sticky flag takes priority over a status-read clear.
            if (push_drop)       overrun  <= 1'b1;
            else if (access[3])  overrun  <= 1'b0;
            if (tick && !pop_ok) underrun <= 1'b1;
            else if (access[3])  underrun <= 1'b0;

            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                prescaler <= '0;
                divcnt    <= div;
                ch_l0     <= SILENCE;
                ch_l1     <= SILENCE;
                ch_r0     <= SILENCE;
                ch_r1     <= SILENCE;
            end else begin
                prescaler <= prescaler + 6'd1;
                if (prescaler == 6'd63)
                    divcnt <= (divcnt == 8'd0) ? div : divcnt - 8'd1;
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                rd_ptr <= rd_ptr + AW'(pop_cnt);
                level  <= level + {5'd0, push_ok} - {4'd0, pop_cnt};
                if (pop_ok) begin
                    ch_l0 <= mem[rd_ptr];
                    ch_l1 <= mem[rd_ptr];
                    ch_r0 <= mode ? mem[rd_ptr + AW'(1)] : mem[rd_ptr];
                    ch_r1 <= mode ? mem[rd_ptr + AW'(1)] : mem[rd_ptr];
                end
            end
        end
    end
endmodule

// File: tb/tb_soundrive_fifo_player.sv
// Bench for soundrive_fifo_player: vector table, directed timing sequences and a randomized run
// against a queue-based reference model.
module tb_soundrive_fifo_player;
    localparam int DEPTH = 32;
    localparam int OP_IDLE = 0, OP_PUSH = 1, OP_STAT = 2, OP_CTRL = 3, OP_DIV = 4, OP_OFF = 5;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b1;
    logic [7:0] d_out;
    logic       d_out_active;
    logic [7:0] ch_l0, ch_l1, ch_r0, ch_r1;
    int         cyc = 0;
    int         last_edge = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    cpu_bus bus ();

    soundrive_fifo_player #(.DEPTH(DEPTH), .DIV_RESET(8'h0F)) dut (
        .clk28(clk28), .rst_n(rst_n), .en(en), .bus(bus),
        .d_out(d_out), .d_out_active(d_out_active),
        .ch_l0(ch_l0), .ch_l1(ch_l1), .ch_r0(ch_r0), .ch_r1(ch_r1)
    );

    always #5 clk28 = ~clk28;
    always @(posedge clk28) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model state: plain byte queue plus a countdown to the next tick edge.
    logic [7:0]  m_q[$];
    logic [31:0] m_ch;
    logic [7:0]  m_div;
    bit          m_mode, m_ov, m_un;
    int          m_cd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.ioreq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        @(posedge clk28); #1;
        bus.a = addr; bus.d = data; bus.ioreq = 1'b1; bus.wr = 1'b1;
        @(posedge clk28); #1;
        last_edge = cyc;
        bus_idle();
    endtask

    task automatic io_read(output logic [7:0] val, output logic act);
        @(posedge clk28); #1;
        bus.a = 8'h7F; bus.ioreq = 1'b1; bus.rd = 1'b1;
        #2;
        val = d_out; act = d_out_active;
        @(posedge clk28); #1;
        bus_idle();
    endtask

    task automatic expect_status(input string name, input logic [7:0] exp);
        logic [7:0] v;
        logic       a;
        io_read(v, a);
        check(name, v, exp);
    endtask

    task automatic wait_ch(input string name, input int budget, output int at);
        logic [7:0] prev;
        prev = ch_l0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk28); #1;
            if (ch_l0 !== prev) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: no channel update within %0d cycles", name, budget);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ch = 32'h80808080; m_div = 8'h0F; m_mode = 0; m_ov = 0; m_un = 0;
        m_cd = (16) * 64;
    endtask

    // Predicts the effect of the next clock edge given this cycle's single bus operation.
    task automatic model_step(input int op, input logic [7:0] dat);
        int         pre;
        logic [7:0] b0, b1;
        pre = m_q.size();
        if (op == OP_STAT) begin m_ov = 0; m_un = 0; end
        if (op == OP_OFF || (op == OP_CTRL && dat[7])) begin
            m_q.delete();
            m_ch = 32'h80808080;
            m_cd = (int'(m_div) + 1) * 64;
        end else begin
            if (m_cd == 1) begin
                m_cd = (int'(m_div) + 1) * 64;
                if (pre >= (m_mode ? 2 : 1)) begin
                    b0 = m_q.pop_front();
                    b1 = m_mode ? m_q.pop_front() : b0;
                    m_ch = {b0, b0, b1, b1};
                end else m_un = 1;
            end else m_cd = m_cd - 1;
            if (op == OP_PUSH) begin
                if (pre < DEPTH) m_q.push_back(dat);
                else m_ov = 1;
            end
        end
        if (op == OP_CTRL) m_mode = dat[0];
        if (op == OP_DIV)  m_div = dat;
    endtask

    task automatic apply_op(input int op, input logic [7:0] dat);
        bus_idle();
        en = 1'b1;
        bus.d = dat;
        case (op)
            OP_PUSH: begin bus.a = 8'h3F; bus.ioreq = 1'b1; bus.wr = 1'b1; end
            OP_STAT: begin bus.a = 8'h7F; bus.ioreq = 1'b1; bus.rd = 1'b1; end
            OP_CTRL: begin bus.a = 8'h7F; bus.ioreq = 1'b1; bus.wr = 1'b1; end
            OP_DIV:  begin bus.a = 8'hBF; bus.ioreq = 1'b1; bus.wr = 1'b1; end
            OP_OFF:  begin en = 1'b0; bus.a = 8'h7F; bus.ioreq = 1'b1; bus.rd = 1'b1; end
            default: ;
        endcase
    endtask

    typedef struct {
        bit         is_rd;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t       vt[14];
        logic [7:0] v;
        logic       act;
        int         t0, at, at2, at3, op, r, pp;
        logic [7:0] dat;
        bit         busy;

        vt[0]  = '{0, 8'hBF, 8'hFF, 8'h00};
        vt[1]  = '{0, 8'h7F, 8'h80, 8'h00};
        vt[2]  = '{1, 8'h7F, 8'h00, 8'h00};
        vt[3]  = '{0, 8'h3F, 8'h11, 8'h00};
        vt[4]  = '{1, 8'h7F, 8'h00, 8'h01};
        vt[5]  = '{0, 8'h3F, 8'h22, 8'h00};
        vt[6]  = '{0, 8'h3F, 8'h33, 8'h00};
        vt[7]  = '{1, 8'h7F, 8'h00, 8'h03};
        vt[8]  = '{0, 8'h7F, 8'h01, 8'h00};
        vt[9]  = '{1, 8'h7F, 8'h00, 8'h03};
        vt[10] = '{0, 8'h3E, 8'h55, 8'h00};
        vt[11] = '{1, 8'h7F, 8'h00, 8'h03};
        vt[12] = '{0, 8'h7F, 8'h81, 8'h00};
        vt[13] = '{1, 8'h7F, 8'h00, 8'h00};

        bus_idle();
        bus.a = 8'h00; bus.d = 8'h00;
        repeat (3) @(posedge clk28);
        #1;
        bus.a = 8'h7F; bus.ioreq = 1'b1; bus.rd = 1'b1;
        #2;
        check("reset status", d_out, 8'h00);
        check("reset active", d_out_active, 1'b1);
        check("reset ch", {ch_l0, ch_l1, ch_r0, ch_r1}, 32'h80808080);
        bus_idle();
        @(posedge clk28); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (vt[i].is_rd) begin
                io_read(v, act);
                check($sformatf("vec[%0d] status", i), v, vt[i].exp);
            end else io_write(vt[i].a, vt[i].d);
        end

        // Mono playback, one pop per 64-cycle tick.
        io_write(8'hBF, 8'h00);
        io_write(8'h7F, 8'h80);
        t0 = last_edge;
        io_write(8'h3F, 8'h10);
        io_write(8'h3F, 8'h20);
        wait_ch("mono first tick", 200, at);
        check("mono first delay", at - t0, 64);
        check("mono first ch", {ch_l0, ch_l1, ch_r0, ch_r1}, 32'h10101010);
        wait_ch("mono second tick", 200, at2);
        check("mono spacing", at2 - at, 64);
        check("mono second ch", {ch_l0, ch_l1, ch_r0, ch_r1}, 32'h20202020);
        expect_status("mono status", 8'h00);

        // Stereo pair pop, then underrun on a single leftover byte.
        io_write(8'h7F, 8'h81);
        t0 = last_edge;
        io_write(8'h3F, 8'hA0);
        io_write(8'h3F, 8'h50);
        io_write(8'h3F, 8'hA1);
        wait_ch("stereo tick", 200, at);
        check("stereo delay", at - t0, 64);
        check("stereo ch", {ch_l0, ch_l1, ch_r0, ch_r1}, 32'hA0A05050);
        repeat (70) @(posedge clk28);
        #1;
        check("stereo hold", {ch_l0, ch_l1, ch_r0, ch_r1}, 32'hA0A05050);
        expect_status("stereo underrun", 8'h41);

        // Fill past capacity with the timer stalled.
        io_write(8'hBF, 8'hFF);
        io_write(8'h7F, 8'h80);
        for (int i = 0; i < DEPTH + 1; i++) io_write(8'h3F, 8'(i));
        expect_status("full overrun", 8'hA0);
        expect_status("full after clear", 8'h20);

        // Long write strobe counts as one push.
        io_write(8'h7F, 8'h80);
        @(posedge clk28); #1;
        bus.a = 8'h3F; bus.d = 8'h77; bus.ioreq = 1'b1; bus.wr = 1'b1;
        repeat (10) @(posedge clk28);
        #1;
        bus_idle();
        expect_status("long strobe", 8'h01);

        // Flush while playing.
        io_write(8'hBF, 8'h00);
        io_write(8'h7F, 8'h80);
        io_write(8'h3F, 8'h33);
        for (int i = 1; i <= 5; i++) io_write(8'h3F, 8'(i));
        wait_ch("flush prep tick", 200, at);
        check("flush prep ch", {ch_l0, ch_l1, ch_r0, ch_r1}, 32'h33333333);
        io_write(8'h7F, 8'h80);
        check("flush ch", {ch_l0, ch_l1, ch_r0, ch_r1}, 32'h80808080);
        expect_status("flush level", 8'h00);
        repeat (70) @(posedge clk28);
        #1;
        expect_status("flush underrun", 8'h40);

        // Divider timing and deferred divider update.
        io_write(8'hBF, 8'h03);
        io_write(8'h7F, 8'h80);
        t0 = last_edge;
        for (int i = 1; i <= 4; i++) io_write(8'h3F, 8'(i));
        wait_ch("div3 tick1", 400, at);
        check("div3 first delay", at - t0, 256);
        repeat (100) @(posedge clk28);
        io_write(8'hBF, 8'h00);
        wait_ch("div3 tick2", 400, at2);
        check("div3 period kept", at2 - at, 256);
        wait_ch("div0 tick3", 200, at3);
        check("div0 period", at3 - at2, 64);
        check("div0 ch", ch_l0, 8'h03);

        // Disable: silence and no port decode.
        en = 1'b0;
        @(posedge clk28); #1;
        check("disable ch", {ch_l0, ch_l1, ch_r0, ch_r1}, 32'h80808080);
        bus.a = 8'h7F; bus.ioreq = 1'b1; bus.rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk28); #1;
            check("disable active", d_out_active, 1'b0);
        end
        bus_idle();
        en = 1'b1;

        // Asynchronous reset in the middle of a write strobe.
        io_write(8'h7F, 8'h80);
        io_write(8'h3F, 8'h5A);
        wait_ch("pre-reset tick", 200, at);
        check("pre-reset ch", ch_l0, 8'h5A);
        @(posedge clk28); #1;
        bus.a = 8'h3F; bus.d = 8'h66; bus.ioreq = 1'b1; bus.wr = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async reset ch", {ch_l0, ch_l1, ch_r0, ch_r1}, 32'h80808080);
        bus_idle();
        @(posedge clk28); #1;
        rst_n = 1'b1;
        model_reset();

        // Randomized run against the reference model; every op is followed by an idle cycle.
        busy = 0;
        for (int c = 0; c < 6000; c++) begin
            check("rand ch", {ch_l0, ch_l1, ch_r0, ch_r1}, m_ch);
            op = OP_IDLE;
            dat = 8'($urandom_range(0, 255));
            pp = ((c / 1000) % 2 == 0) ? 40 : 4;
            if (c == 0) op = OP_STAT;
            else if (!busy) begin
                r = $urandom_range(0, 99);
                if (r < pp) op = OP_PUSH;
                else if (r < pp + 15) op = OP_STAT;
                else if (r < pp + 23) begin
                    op = OP_CTRL;
                    dat = 8'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) dat[7] = 1'b1;
                end else if (r < pp + 28) begin
                    op = OP_DIV;
                    dat = 8'($urandom_range(0, 2));
                end else if (r < pp + 30) op = OP_OFF;
            end
            busy = (op != OP_IDLE);
            apply_op(op, dat);
            #1;
            if (op == OP_STAT) check("rand status", d_out, {m_ov, m_un, 6'(m_q.size())});
            if (op == OP_OFF) check("rand off active", d_out_active, 1'b0);
            model_step(op, dat);
            @(posedge clk28); #1;
        end
        bus_idle();
        en = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
